uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the board UART transmitter between two byte sources: CPU peripheral store path (req0) and debug/status reporter (req1).
- Round-robin arbitration in front of a built-in 8N1 serial transmit engine driving the UART_TX pin.
- Sits inside the CPU top level next to the peripheral bus.
- Replaces a single-owner UART TX, so that debug traffic never starves CPU output.

Parameters:
- CLKS_PER_BIT, 10416: sysclk cycles per UART bit (100 MHz / 9600 baud). Must be >= 2.
- CNT_W, 14: width of the baud counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- sysclk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  CPU requester has a byte to send.
- req0_data  in  8  CPU byte.
- req0_ready  out  1  CPU byte accepted this cycle when valid&ready.
- req1_valid  in  1  debug requester has a byte to send.
- req1_data  in  8  debug byte.
- req1_ready  out  1  debug byte accepted this cycle when valid&ready.
- UART_TX  out  1  serial line, idle high.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  1  requester owning the current or last frame.
- tx_done  out  1  one-cycle pulse at the end of each stop bit.
- frame_cnt  out  16  number of completed frames, wraps 0xFFFF -> 0.

Behaviour:
- Reset values: UART_TX=1, busy=0, grant_id=0, tx_done=0, frame_cnt=0, state=IDLE, last_grant=1. req0_ready and req1_ready are 0 during any cycle where reset=1.
- States: IDLE, START, DATA, STOP.
- Readiness and arbitration:
  - Ready signals are combinational from state, last_grant and the valids.
  - Ready is asserted only in IDLE, only to the winner, and never to both.
  - Winner: if exactly one valid, that one. If both valid, the requester != last_grant.
- Handshake: valid&ready in IDLE.
  - Latch the data byte into the shift register.
  - grant_id <= winner, last_grant <= winner.
  - baud_cnt <= 0, go to START.
- Requester protocol:
  - A requester holds valid and data stable until its handshake.
  - Data is sampled only on the handshake cycle; later changes are ignored.
- START: UART_TX=0 for CLKS_PER_BIT cycles, then go to DATA with bit_cnt=0.
- DATA:
  - UART_TX = shift[bit_cnt], LSB first, each bit for CLKS_PER_BIT cycles.
  - After bit 7, go to STOP.
- STOP:
  - UART_TX=1 for CLKS_PER_BIT cycles.
  - On the last cycle of STOP: tx_done=1 and frame_cnt+1 for one cycle, next state IDLE.
- UART_TX is registered. The first START-level cycle is the cycle after the handshake edge.
- Frame length: a frame occupies exactly 10*CLKS_PER_BIT cycles from the first start-bit cycle.
- Back-to-back frames:
  - At least one IDLE cycle separates consecutive frames, because the handshake happens in IDLE.
  - Effective stop width is therefore >= CLKS_PER_BIT+1.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and reloads to 0 at each bit boundary.
  - No drift across the frame.
- Valid dropped before handshake: no effect and no grant change.
- Reset mid-frame:
  - On the reset edge, abort: UART_TX=1, state=IDLE, frame_cnt=0, last_grant=1.
  - The partial frame is lost and tx_done is not pulsed.
- busy=1 from the cycle after the handshake through the last STOP cycle.
- tx_done and the frame_cnt increment happen on the same cycle.

Test Plan (CLKS_PER_BIT=4):
1. Single frame.
   - Stimulus: after reset, req0_valid=1, data=0x55.
   - Required: req0_ready=1 in the same cycle.
   - Required UART_TX sequence after the handshake: 4 cycles 0 (start), then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then 4 cycles 1.
   - Required: tx_done pulses at cycle 40; frame_cnt=1; busy high for exactly 40 cycles.
2. Simultaneous request.
   - Stimulus: req0 (0xA3) and req1 (0x3C) both valid on the first cycle after reset.
   - Required: req0 granted first (grant_id=0); req1_ready stays 0 for the whole frame.
   - Required: req1 granted on the first IDLE cycle after tx_done; grant_id=1; line carries 0x3C; frame_cnt=2.
3. Fairness.
   - Stimulus: both requesters hold valid continuously for 6 frames.
   - Required grant order: 0,1,0,1,0,1.
   - Required: exactly 1 idle-high cycle between consecutive frames.
4. Reset mid-frame.
   - Stimulus: assert reset for 1 cycle during DATA bit 3 of 0x00.
   - Required: UART_TX=1 the cycle after the edge; busy=0; frame_cnt=0; no tx_done.
   - Required: a subsequent req1-only request is accepted immediately.
5. Data hold.
   - Stimulus: change req0_data from 0xF0 to 0x0F on the cycle after the handshake.
   - Required: the transmitted bits are those of 0xF0.
6. Counter wrap.
   - Stimulus: preload frame_cnt to 0xFFFF via a bench force, then complete one frame.
   - Required: frame_cnt=0x0000 and tx_done=1 on that cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter for two byte sources in front of an 8N1 UART transmitter
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int CNT_W        = 14
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic        UART_TX,
  output logic        busy,
  output logic        grant_id,
  output logic        tx_done,
  output logic [15:0] frame_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             last_grant;

  logic idle;
  logic bit_end;
  logic pick0;
  logic pick1;

  // Winner selection: a lone requester wins, a tie goes to whoever did not own the last frame.
  always_comb begin
    idle    = (state == IDLE);
    bit_end = (baud_cnt == BAUD_LAST);
    pick0   = req0_valid && (!req1_valid || last_grant);
    pick1   = req1_valid && (!req0_valid || !last_grant);
  end

  // Ready only in IDLE and never while reset is held; pick0/pick1 are mutually exclusive.
  assign req0_ready = idle && !reset && pick0;
  assign req1_ready = idle && !reset && pick1;
  assign busy       = !idle;
  // Pulse during the final stop-bit cycle, the same cycle whose edge bumps frame_cnt.
  assign tx_done    = !reset && (state == STOP) && bit_end;

  // Frame sequencer: the line level is registered so each bit is a whole number of baud periods.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      UART_TX    <= 1'b1;
      frame_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            shift      <= req1_ready ? req1_data : req0_data;
            grant_id   <= req1_ready;
            last_grant <= req1_ready;
            baud_cnt   <= '0;
            UART_TX    <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            UART_TX  <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              UART_TX <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              UART_TX <= shift[bit_cnt + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            frame_cnt <= frame_cnt + 16'd1;
            state     <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic [7:0]  req0_data = 8'h00;
  logic        req1_valid = 1'b0;
  logic [7:0]  req1_data = 8'h00;
  logic        req0_ready;
  logic        req1_ready;
  logic        UART_TX;
  logic        busy;
  logic        grant_id;
  logic        tx_done;
  logic [15:0] frame_cnt;

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB), .CNT_W(4)) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .UART_TX    (UART_TX),
    .busy       (busy),
    .grant_id   (grant_id),
    .tx_done    (tx_done),
    .frame_cnt  (frame_cnt)
  );

  always #5 sysclk = ~sysclk;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
  } sb_t;

  typedef struct {
    logic       v0;
    logic       v1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       r0;
    logic       r1;
    logic       g;
  } vec_t;

  sb_t  sbq[$];
  sb_t  cur;
  logic grant_log[$];
  int   gap_log[$];
  vec_t vt[10];

  int   cyc = 0;
  int   hs_count = 0;
  int   frames_done = 0;
  int   tx_done_seen = 0;
  logic mon_active = 1'b0;
  int   k = 0;
  int   mon_err = 0;
  int   end_cyc = -100;
  logic exp_line;

  int   n;
  int   r1_hits;
  int   hs_base;
  int   prev_hs;
  int   seen;
  logic found;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge sysclk);
    while (busy && w < 200) begin
      @(negedge sysclk);
      w++;
    end
    if (w >= 200) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: busy still %0b after %0d cycles", busy, w);
    end
  endtask

  task automatic do_reset();
    @(posedge sysclk); #1;
    reset = 1'b1;
    @(posedge sysclk); #1;
    reset = 1'b0;
  endtask

  // Line monitor and scoreboard: handshakes push, each decoded frame pops and is checked cycle by cycle.
  always @(negedge sysclk) begin
    cyc++;
    if (tx_done === 1'b1) tx_done_seen++;
    if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
      total++;
      bad++;
      $display("FAIL both_ready: req0_ready=1 req1_ready=1 required at most one");
    end
    if (reset) begin
      mon_active = 1'b0;
      end_cyc = -100;
    end else begin
      if (!mon_active && UART_TX === 1'b0) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: start bit with empty scoreboard at cycle %0d", cyc);
        end else begin
          cur = sbq.pop_front();
          mon_active = 1'b1;
          k = 0;
          mon_err = 0;
          if (end_cyc >= 0) gap_log.push_back(cyc - end_cyc - 1);
          grant_log.push_back(cur.id);
        end
      end
      if (mon_active) begin
        if (k < CPB) exp_line = 1'b0;
        else if (k < 9 * CPB) exp_line = cur.data[(k - CPB) / CPB];
        else exp_line = 1'b1;
        if (UART_TX !== exp_line) mon_err++;
        if (tx_done !== (k == FRAME - 1)) mon_err++;
        if (busy !== 1'b1) mon_err++;
        if (grant_id !== cur.id) mon_err++;
        k++;
        if (k == FRAME) begin
          chk($sformatf("frame_%0h_id%0b_errs", cur.data, cur.id), mon_err, 0);
          mon_active = 1'b0;
          end_cyc = cyc;
          frames_done++;
        end
      end
      if (req0_valid && req0_ready) begin
        sbq.push_back({1'b0, req0_data});
        hs_count++;
      end
      if (req1_valid && req1_ready) begin
        sbq.push_back({1'b1, req1_data});
        hs_count++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Arbitration table, starting from reset (last_grant=1, grant_id=0).
    vt[0] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 8'h12, 8'hE1, 1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b1, 8'h34, 8'hC3, 1'b0, 1'b1, 1'b1};
    vt[3] = '{1'b1, 1'b1, 8'h56, 8'hA5, 1'b1, 1'b0, 1'b0};
    vt[4] = '{1'b0, 1'b1, 8'h78, 8'h87, 1'b0, 1'b1, 1'b1};
    vt[5] = '{1'b0, 1'b1, 8'h9A, 8'h01, 1'b0, 1'b1, 1'b1};
    vt[6] = '{1'b1, 1'b1, 8'hBC, 8'hFE, 1'b1, 1'b0, 1'b0};
    vt[7] = '{1'b1, 1'b0, 8'hDE, 8'h7F, 1'b1, 1'b0, 1'b0};
    vt[8] = '{1'b1, 1'b1, 8'hF1, 8'h80, 1'b0, 1'b1, 1'b1};
    vt[9] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};

    // Reset state, with both valids held high to prove ready is masked during reset.
    reset = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_uart_tx", UART_TX, 1);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    @(posedge sysclk); #1;
    reset = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    foreach (vt[i]) begin
      @(posedge sysclk); #1;
      req0_valid = vt[i].v0;
      req1_valid = vt[i].v1;
      req0_data  = vt[i].d0;
      req1_data  = vt[i].d1;
      @(negedge sysclk);
      chk($sformatf("vec%0d_req0_ready", i), req0_ready, vt[i].r0);
      chk($sformatf("vec%0d_req1_ready", i), req1_ready, vt[i].r1);
      @(posedge sysclk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk($sformatf("vec%0d_busy", i), busy, vt[i].r0 | vt[i].r1);
      wait_idle();
      chk($sformatf("vec%0d_grant_id", i), grant_id, vt[i].g);
    end

    // Single frame: 0x55 from req0, busy for exactly one frame length.
    do_reset();
    req0_valid = 1'b1;
    req0_data = 8'h55;
    @(negedge sysclk);
    chk("t1_req0_ready", req0_ready, 1);
    @(posedge sysclk); #1;
    req0_valid = 1'b0;
    seen = tx_done_seen;
    n = 0;
    @(negedge sysclk);
    while (busy && n < 100) begin
      n++;
      @(negedge sysclk);
    end
    chk("t1_busy_cycles", n, FRAME);
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_tx_done_count", tx_done_seen - seen, 1);

    // Simultaneous request: req0 first, req1 held off until the next IDLE cycle.
    do_reset();
    req0_valid = 1'b1;
    req0_data = 8'hA3;
    req1_valid = 1'b1;
    req1_data = 8'h3C;
    @(negedge sysclk);
    chk("t2_req0_ready", req0_ready, 1);
    chk("t2_req1_ready_first", req1_ready, 0);
    @(posedge sysclk); #1;
    req0_valid = 1'b0;
    chk("t2_grant_first", grant_id, 0);
    n = 0;
    r1_hits = 0;
    @(negedge sysclk);
    while (busy && n < 100) begin
      if (req1_ready) r1_hits++;
      n++;
      @(negedge sysclk);
    end
    chk("t2_r1_ready_during_frame", r1_hits, 0);
    chk("t2_r1_ready_idle", req1_ready, 1);
    @(posedge sysclk); #1;
    req1_valid = 1'b0;
    chk("t2_grant_second", grant_id, 1);
    wait_idle();
    chk("t2_frame_cnt", frame_cnt, 2);

    // Fairness: both requesters held valid for six frames.
    do_reset();
    grant_log.delete();
    gap_log.delete();
    hs_base = hs_count;
    prev_hs = hs_count;
    req0_valid = 1'b1;
    req0_data = 8'h11;
    req1_valid = 1'b1;
    req1_data = 8'h22;
    n = 0;
    while (n < 1000) begin
      @(posedge sysclk); #1;
      n++;
      if (hs_count != prev_hs) begin
        prev_hs = hs_count;
        if (sbq[sbq.size() - 1].id) req1_data = req1_data + 8'h35;
        else req0_data = req0_data + 8'h29;
        if (hs_count - hs_base == 6) break;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("t3_handshakes", hs_count - hs_base, 6);
    wait_idle();
    chk("t3_grant_count", grant_log.size(), 6);
    chk("t3_gap_count", gap_log.size(), 5);
    for (int i = 0; i < 6; i++) begin
      if (i < grant_log.size()) chk($sformatf("t3_grant%0d", i), grant_log[i], i % 2);
    end
    for (int i = 0; i < 5; i++) begin
      if (i < gap_log.size()) chk($sformatf("t3_gap%0d", i), gap_log[i], 1);
    end

    // Reset during data bit 3 of 0x00, then an immediate req1-only request.
    @(posedge sysclk); #1;
    req0_valid = 1'b1;
    req0_data = 8'h00;
    @(negedge sysclk);
    chk("t4_req0_ready", req0_ready, 1);
    @(posedge sysclk); #1;
    req0_valid = 1'b0;
    repeat (17) @(posedge sysclk);
    #1;
    seen = tx_done_seen;
    reset = 1'b1;
    @(posedge sysclk); #1;
    reset = 1'b0;
    @(negedge sysclk);
    chk("t4_uart_tx", UART_TX, 1);
    chk("t4_busy", busy, 0);
    chk("t4_frame_cnt", frame_cnt, 0);
    chk("t4_no_tx_done", tx_done_seen - seen, 0);
    req1_valid = 1'b1;
    req1_data = 8'h96;
    #1;
    chk("t4_req1_ready", req1_ready, 1);
    @(posedge sysclk); #1;
    req1_valid = 1'b0;
    chk("t4_grant_id", grant_id, 1);
    wait_idle();
    chk("t4_frame_cnt_after", frame_cnt, 1);

    // Data hold: the byte changes right after the handshake; 0xF0 must still go out.
    @(posedge sysclk); #1;
    req0_valid = 1'b1;
    req0_data = 8'hF0;
    @(negedge sysclk);
    chk("t5_req0_ready", req0_ready, 1);
    @(posedge sysclk); #1;
    req0_data = 8'h0F;
    req0_valid = 1'b0;
    wait_idle();
    chk("t5_frame_cnt", frame_cnt, 2);

    // Counter wrap from 0xFFFF.
    @(negedge sysclk);
    force dut.frame_cnt = 16'hFFFF;
    @(posedge sysclk); #1;
    release dut.frame_cnt;
    @(negedge sysclk);
    chk("t6_preload", frame_cnt, 16'hFFFF);
    @(posedge sysclk); #1;
    req1_valid = 1'b1;
    req1_data = 8'h5A;
    @(negedge sysclk);
    chk("t6_req1_ready", req1_ready, 1);
    @(posedge sysclk); #1;
    req1_valid = 1'b0;
    n = 0;
    found = 1'b0;
    while (n < 100 && !found) begin
      @(negedge sysclk);
      n++;
      if (tx_done) found = 1'b1;
    end
    chk("t6_tx_done_found", found, 1);
    chk("t6_tx_done_cycle", n, FRAME);
    @(negedge sysclk);
    chk("t6_frame_cnt_wrap", frame_cnt, 16'h0000);

    repeat (3) @(negedge sysclk);
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
